// File: rtl/fft_integ_pkg.sv
// Shared types and helpers for the FFT bin integrator: FSM state encoding,
// the per-integration configuration record and the averaging-depth clamp.
package fft_integ_pkg;

  localparam int CFG_K_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic [CFG_K_W-1:0] log2_avgs;
    logic               mean;
  } cfg_t;

  // Limit the requested averaging depth to the largest depth the datapath supports.
  function automatic logic [CFG_K_W-1:0] sat_k(input logic [CFG_K_W-1:0] k,
                                               input logic [CFG_K_W-1:0] max_k);
    return (k > max_k) ? max_k : k;
  endfunction

endpackage

// File: rtl/bin_acc_ram.sv
// Per-bin accumulator storage: BINS words of WIDTH bits with one asynchronous
// read port and one synchronous write port sharing a single address.
module bin_acc_ram #(
  parameter int BINS  = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(BINS)-1:0] addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [BINS];

  // Write the updated running sum for the addressed bin.
  // NOTE: the array has no reset; the first frame of every integration
  // overwrites each word, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/fft_bin_integrator.sv
// Integrates a streaming FFT frame of BINS signed bins over 2^k frames and
// emits each bin's sum (or arithmetic-shift mean) one cycle after that bin's
// final-frame beat, back to back with the next integration.
module fft_bin_integrator
  import fft_integ_pkg::*;
#(
  parameter int BINS          = 4,
  parameter int N             = 16,
  parameter int SUM_WIDTH     = 32,
  parameter int MAX_LOG2_AVGS = 10
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic                               enable,
  input  logic [$clog2(MAX_LOG2_AVGS+1)-1:0] cfg_log2_avgs,
  input  logic                               cfg_mean,
  input  logic                               in_valid,
  input  logic [N-1:0]                       in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  output logic [SUM_WIDTH-1:0]               out_data,
  output logic [$clog2(BINS)-1:0]            out_bin,
  output logic                               out_last,
  output logic                               frame_err,
  output logic                               busy
);

  localparam int BW = $clog2(BINS);
  localparam int FW = (MAX_LOG2_AVGS > 0) ? MAX_LOG2_AVGS : 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(BINS - 1);

  if (SUM_WIDTH < N + MAX_LOG2_AVGS) begin : g_width_check
    $error("fft_bin_integrator: SUM_WIDTH must be at least N + MAX_LOG2_AVGS");
  end

  state_t                      state_q, state_d;
  cfg_t                        cfg_q, cfg_new;
  logic [BW-1:0]               bin_idx;
  logic [FW-1:0]               frame_cnt, frame_max;
  logic signed [SUM_WIDTH-1:0] acc_rd, sample, base, sum, result;
  logic                        beat, bad_frame, good_beat, final_frame, int_done;

  assign cfg_new = '{log2_avgs: sat_k(CFG_K_W'(cfg_log2_avgs), CFG_K_W'(MAX_LOG2_AVGS)),
                     mean:      cfg_mean};
  assign busy    = (state_q == ACCUM);

  // Classify the current beat and decide the next FSM state.
  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    beat        = (state_q == ACCUM) && in_valid;
    bad_frame   = beat && (in_last != (bin_idx == LAST_BIN));
    good_beat   = beat && !bad_frame;
    frame_max   = FW'((64'd1 << cfg_q.log2_avgs) - 64'd1);
    final_frame = (frame_cnt == frame_max);
    int_done    = good_beat && in_last && final_frame;
    state_d     = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACCUM;
      ACCUM:   if (int_done && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running-sum update: frame 0 overwrites the stored value, later frames add.
  always_comb begin
    sample = SUM_WIDTH'($signed(in_data));
    base   = (frame_cnt == '0) ? '0 : acc_rd;
    sum    = base + sample;
    result = cfg_q.mean ? (sum >>> cfg_q.log2_avgs) : sum;
  end

  bin_acc_ram #(
    .BINS  (BINS),
    .WIDTH (SUM_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (good_beat),
    .addr  (bin_idx),
    .wdata (sum),
    .rdata (acc_rd)
  );

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters, configuration latch and the registered result/error outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cfg_q     <= '0;
      bin_idx   <= '0;
      frame_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      if (state_q == IDLE && enable) begin
        cfg_q     <= cfg_new;
        bin_idx   <= '0;
        frame_cnt <= '0;
      end
      if (bad_frame) begin
        frame_err <= 1'b1;
        bin_idx   <= '0;
        frame_cnt <= '0;
        cfg_q     <= cfg_new;
      end else if (good_beat) begin
        bin_idx <= in_last ? '0 : bin_idx + 1'b1;
        if (in_last) frame_cnt <= final_frame ? '0 : frame_cnt + 1'b1;
        if (int_done) cfg_q <= cfg_new;
        if (final_frame) begin
          out_valid <= 1'b1;
          out_data  <= result;
          out_bin   <= bin_idx;
          out_last  <= in_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_integrator.sv
// Scoreboard bench for fft_bin_integrator: stimulus pushes expected results
// from a frame-level reference model; a negedge monitor pops and compares.
module tb_fft_bin_integrator;

  localparam int BINS      = 4;
  localparam int N         = 16;
  localparam int SUM_WIDTH = 32;
  localparam int MAX_K     = 10;
  localparam int KW        = $clog2(MAX_K + 1);

  logic                    clk = 1'b0;
  logic                    areset, enable, cfg_mean, in_valid, in_last;
  logic [KW-1:0]           cfg_log2_avgs;
  logic [N-1:0]            in_data;
  logic                    out_valid, out_last, frame_err, busy;
  logic [SUM_WIDTH-1:0]    out_data;
  logic [$clog2(BINS)-1:0] out_bin;

  typedef struct {
    longint data;
    int     bin;
    bit     last;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     err_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;

  int     mk, mframes, mbin;
  bit     mmean, mactive, pending_stop;
  longint macc[BINS];
  int     fr[BINS];

  fft_bin_integrator #(
    .BINS          (BINS),
    .N             (N),
    .SUM_WIDTH     (SUM_WIDTH),
    .MAX_LOG2_AVGS (MAX_K)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .enable        (enable),
    .cfg_log2_avgs (cfg_log2_avgs),
    .cfg_mean      (cfg_mean),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_bin       (out_bin),
    .out_last      (out_last),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q = a / d;
    if ((a % d) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int rand16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Start a fresh integration in the model using the configuration now on the pins.
  task automatic model_begin();
    mk      = (int'(cfg_log2_avgs) > MAX_K) ? MAX_K : int'(cfg_log2_avgs);
    mmean   = cfg_mean;
    mframes = 0;
    mbin    = 0;
    foreach (macc[i]) macc[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Drive one beat and let the model predict the response it should cause.
  task automatic send_beat(input int v, input bit last, input bit gaps);
    exp_t e;
    if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    @(negedge clk);
    if (pending_stop) begin
      enable       = 1'b0;
      pending_stop = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = N'(v);
    in_last  = last;
    if (mactive) begin
      if (last != (mbin == BINS - 1)) begin
        err_q.push_back(cyc + 1);
        model_begin();
      end else begin
        macc[mbin] += v;
        if (mframes == (1 << mk) - 1) begin
          e.data = mmean ? fdiv(macc[mbin], longint'(1) << mk) : macc[mbin];
          e.bin  = mbin;
          e.last = last;
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
        if (last) begin
          mbin = 0;
          mframes++;
          if (mframes == (1 << mk)) begin
            if (enable) model_begin();
            else mactive = 1'b0;
          end
        end else begin
          mbin++;
        end
      end
    end
  endtask

  task automatic send_frame(input int f[BINS], input bit gaps);
    for (int b = 0; b < BINS; b++) send_beat(f[b], b == BINS - 1, gaps);
  endtask

  task automatic rand_frame();
    foreach (fr[i]) fr[i] = rand16();
  endtask

  task automatic start(input int k, input bit mean);
    idle(1);
    cfg_log2_avgs = KW'(k);
    cfg_mean      = mean;
    enable        = 1'b1;
    @(negedge clk);
    model_begin();
    mactive = 1'b1;
    check("busy_after_start", longint'(busy), 1);
  endtask

  task automatic finish_integ(input string name);
    idle(3);
    check(name, longint'(busy), 0);
  endtask

  // Monitor: every presented result or error pulse must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (!areset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", longint'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'($signed(out_data)), e.data);
          check("out_bin", longint'(out_bin), e.bin);
          check("out_last", longint'(out_last), e.last);
          check("out_latency_cycle", cyc, e.cyc);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          check("spurious_frame_err", longint'(frame_err), 0);
        end else begin
          ec = err_q.pop_front();
          check("frame_err_cycle", cyc, ec);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset        = 1'b1;
    enable        = 1'b0;
    cfg_log2_avgs = '0;
    cfg_mean      = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_last       = 1'b0;
    mactive       = 1'b0;
    pending_stop  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_out_bin", longint'(out_bin), 0);
    check("reset_out_last", longint'(out_last), 0);
    check("reset_frame_err", longint'(frame_err), 0);
    check("reset_busy", longint'(busy), 0);
    areset = 1'b0;

    // k=0: each frame is emitted directly, back to back.
    start(0, 1'b0);
    fr = '{1, 2, 3, 4};
    send_frame(fr, 1'b0);
    rand_frame();
    pending_stop = 1'b1;
    send_frame(fr, 1'b0);
    finish_integ("busy_after_t1");

    // Beats while idle are ignored.
    fr = '{100, 200, 300, 400};
    send_frame(fr, 1'b0);
    idle(3);

    // k=3 sum, config wiggled mid-integration, then a second integration of 1s.
    start(3, 1'b0);
    fr = '{1, 2, 3, 4};
    for (int f = 0; f < 8; f++) begin
      if (f == 2) begin cfg_log2_avgs = KW'(1); cfg_mean = 1'b1; end
      if (f == 6) begin cfg_log2_avgs = KW'(3); cfg_mean = 1'b0; end
      send_frame(fr, 1'b0);
    end
    fr = '{1, 1, 1, 1};
    for (int f = 0; f < 8; f++) begin
      if (f == 7) pending_stop = 1'b1;
      send_frame(fr, 1'b0);
    end
    finish_integ("busy_after_t2");

    // k=2 mean: negative floor rounding and positive full-scale.
    start(2, 1'b1);
    for (int f = 0; f < 4; f++) begin
      fr[0] = -(f + 1);
      fr[1] = rand16();
      fr[2] = rand16();
      fr[3] = 32767;
      if (f == 3) pending_stop = 1'b1;
      send_frame(fr, 1'b0);
    end
    finish_integ("busy_after_t3");

    // Framing errors at the start of an integration, then clean k=1 frames.
    start(1, 1'b0);
    send_beat(5, 1'b0, 1'b0);
    send_beat(6, 1'b0, 1'b0);
    send_beat(7, 1'b1, 1'b0);
    for (int b = 0; b < BINS; b++) send_beat(rand16(), 1'b0, 1'b0);
    rand_frame();
    send_frame(fr, 1'b0);
    rand_frame();
    pending_stop = 1'b1;
    send_frame(fr, 1'b0);
    finish_integ("busy_after_t4");

    // k=3 with random valid gaps on the same data pattern.
    start(3, 1'b0);
    fr = '{1, 2, 3, 4};
    for (int f = 0; f < 8; f++) begin
      if (f == 7) pending_stop = 1'b1;
      send_frame(fr, 1'b1);
    end
    finish_integ("busy_after_t5");

    // Requested depth above the maximum clamps to 2^MAX_K frames.
    start(15, 1'b1);
    for (int f = 0; f < (1 << MAX_K); f++) begin
      rand_frame();
      if (f == (1 << MAX_K) - 1) pending_stop = 1'b1;
      send_frame(fr, 1'b0);
    end
    finish_integ("busy_after_clamp");

    // Asynchronous reset mid frame 5 of k=3; k changes to 1 while in reset.
    start(3, 1'b0);
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(fr, 1'b0);
    end
    send_beat(rand16(), 1'b0, 1'b0);
    send_beat(rand16(), 1'b0, 1'b0);
    idle(1);
    #2;
    areset        = 1'b1;
    cfg_log2_avgs = KW'(1);
    #1;
    check("async_reset_busy", longint'(busy), 0);
    check("async_reset_out_valid", longint'(out_valid), 0);
    check("async_reset_out_data", longint'(out_data), 0);
    check("async_reset_out_bin", longint'(out_bin), 0);
    check("async_reset_out_last", longint'(out_last), 0);
    check("async_reset_frame_err", longint'(frame_err), 0);
    mactive = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    start(1, 1'b0);
    rand_frame();
    send_frame(fr, 1'b0);
    rand_frame();
    pending_stop = 1'b1;
    send_frame(fr, 1'b0);
    finish_integ("busy_after_t6");

    for (int i = 0; i < 20 && (exp_q.size() != 0 || err_q.size() != 0); i++) @(negedge clk);
    check("results_outstanding", exp_q.size(), 0);
    check("errors_outstanding", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
